// File: rtl/if_id_fetch_queue.sv
// IF/ID instruction fetch queue: circular buffer of {PC+4, instruction} pairs
// with valid/ready handshakes on both sides, show-ahead head and branch flush.
module if_id_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_pc4,
  input  logic [DW-1:0]          in_ir,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_pc4,
  output logic [DW-1:0]          out_ir,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic [AW-1:0] mem_pc4 [DEPTH];
  logic [DW-1:0] mem_ir  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full queue never accepts, even when ID pops in the same cycle.
  always_comb begin
    in_ready  = ~rst & (count != CNT_FULL);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_pc4   = out_valid ? mem_pc4[rd_ptr] : '0;
    out_ir    = out_valid ? mem_ir[rd_ptr]  : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a pair presented alongside flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_pc4[wr_ptr] <= in_pc4;
      mem_ir[wr_ptr]  <= in_ir;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_if_id_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc4;
  logic [31:0] in_ir;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [31:0] out_ir;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic [63:0] pushed[$];

  if_id_fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_ir(in_ir), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc4(out_pc4), .out_ir(out_ir), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; the model applies the handshake rules to the inputs
  // held across the edge, then control returns at the falling edge.
  task automatic cycle();
    bit m_push, m_pop;
    m_push = in_valid && !rst && (mq.size() < DEPTH);
    m_pop  = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({in_pc4, in_ir});
        pushed.push_back({in_pc4, in_ir});
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_pair();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc4 = '0; in_ir = '0;
    cycle(); cycle();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 ||
        out_pc4 !== 32'h0 || out_ir !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d in_ready=%b pc4=%h ir=%h, want 0/0/0/0/0",
               out_valid, count, in_ready, out_pc4, out_ir);
    end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_pc4 = 32'h0000_0004; in_ir = 32'h0022_4020; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc4 !== 32'h0000_0004 || out_ir !== 32'h0022_4020 ||
        count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: valid=%b pc4=%h ir=%h count=%0d, want 1/00000004/00224020/1",
               out_valid, out_pc4, out_ir, count);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_ir !== 32'h0) begin
      errors++;
      $display("FAIL single_drain: valid=%b count=%0d ir=%h, want 0/0/0", out_valid, count, out_ir);
    end
  endtask

  task automatic test_fill_full(output logic [63:0] vals [4]);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vals[i] = rnd_pair();
      in_valid = 1'b1; {in_pc4, in_ir} = vals[i];
      cycle();
    end
    in_valid = 1'b0; #1;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d in_ready=%b, want 4/0", count, in_ready);
    end
    in_valid = 1'b1; {in_pc4, in_ir} = rnd_pair();
    cycle();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || {out_pc4, out_ir} !== vals[0]) begin
      errors++;
      $display("FAIL fifth_rejected: count=%0d head=%h, want 4/%h", count, {out_pc4, out_ir}, vals[0]);
    end
  endtask

  task automatic test_pop_from_full(input logic [63:0] vals [4]);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; #1;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_from_full: count=%0d in_ready=%b, want 3/1", count, in_ready);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_pc4, out_ir} !== vals[i]) begin
        errors++;
        $display("FAIL drain_order[%0d]: valid=%b head=%h, want 1/%h", i, out_valid,
                 {out_pc4, out_ir}, vals[i]);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] seq[$];
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seq.push_back(rnd_pair());
      in_valid = 1'b1; {in_pc4, in_ir} = seq[i];
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      seq.push_back(rnd_pair());
      in_valid = 1'b1; out_ready = 1'b1; {in_pc4, in_ir} = seq[i + 2];
      checks++;
      if ({out_pc4, out_ir} !== seq[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: head=%h want %h", i, {out_pc4, out_ir}, seq[i]);
      end
      cycle();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count[%0d]: count=%0d want 2", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      checks++;
      if ({out_pc4, out_ir} !== seq[i]) begin
        errors++;
        $display("FAIL b2b_tail[%0d]: head=%h want %h", i, {out_pc4, out_ir}, seq[i]);
      end
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [63:0] fresh;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; {in_pc4, in_ir} = rnd_pair();
      cycle();
    end
    flush = 1'b1; in_valid = 1'b1; in_pc4 = 32'h0000_005C; in_ir = 32'h0800_0018;
    out_ready = 1'($urandom_range(0, 1));
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_ir !== 32'h0 || out_pc4 !== 32'h0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b pc4=%h ir=%h, want 0/0/0/0",
               count, out_valid, out_pc4, out_ir);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    fresh = rnd_pair();
    in_valid = 1'b1; {in_pc4, in_ir} = fresh;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || {out_pc4, out_ir} !== fresh) begin
      errors++;
      $display("FAIL post_flush_push: count=%0d head=%h, want 1/%h", count, {out_pc4, out_ir}, fresh);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] fresh;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; {in_pc4, in_ir} = rnd_pair();
      cycle();
    end
    rst = 1'b1;
    cycle();
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b count=%0d in_ready=%b, want 0/0/0", out_valid, count, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release: in_ready=%b want 1", in_ready);
    end
    fresh = rnd_pair();
    in_valid = 1'b1; {in_pc4, in_ir} = fresh;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {out_pc4, out_ir} !== fresh || count !== 3'd1) begin
      errors++;
      $display("FAIL mid_reset_push: valid=%b head=%h count=%0d, want 1/%h/1",
               out_valid, {out_pc4, out_ir}, count, fresh);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] exp_head;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = ($urandom_range(0, 99) < 4);
      rst       = ($urandom_range(0, 99) < 2);
      {in_pc4, in_ir} = rnd_pair();
      #1;
      exp_head = (mq.size() != 0) ? mq[0] : 64'h0;
      checks++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
          {out_pc4, out_ir} !== exp_head ||
          in_ready !== (!rst && mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d valid=%b head=%h in_ready=%b, want %0d/%b/%h/%b",
                 i, count, out_valid, {out_pc4, out_ir}, in_ready, mq.size(),
                 mq.size() != 0, exp_head, !rst && mq.size() < DEPTH);
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] fill_vals [4];
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_full(fill_vals);
    test_pop_from_full(fill_vals);
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
